mul_ram_sequencer: RTL
======================

// Module: mul_ram_sequencer
// PURPOSE
//  Sequencer for the dual-RAM16x8 -> multiplier -> RAM16x16 datapath.
//  - Loads COUNT operand pairs into both 8-bit RAMs over a valid/ready port.
//  - Runs a pipelined multiply pass, writing each A*B product into the 16-bit RAM.
//  - Streams the products out under valid/ready backpressure, then pulses done.
//  - Generates enables and addresses only; operand/product data wires go RAM-to-RAM in the top.
// PARAMETERS
//  ADDR_W  4   RAM address width
//  DEPTH   16  entries per RAM (= 2**ADDR_W)
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-high; clears all state and outputs
//  start      in   1         pulse; sampled in IDLE only
//  count      in   ADDR_W+1  entries to process, 0..DEPTH; sampled with start
//  in_valid   in   1         operand pair presented on data_in_0/data_in_1
//  in_ready   out  1         sequencer accepts an operand pair this cycle
//  out_valid  out  1         RAM16x16 data_out holds a valid product
//  out_ready  in   1         consumer takes the product
//  ab_addr    out  ADDR_W    address for both RAM16x8
//  ab_w_en    out  1         write enable, both RAM16x8
//  ab_op_en   out  1         read enable, both RAM16x8
//  c_addr     out  ADDR_W    address for RAM16x16
//  c_w_en     out  1         write enable, RAM16x16
//  c_op_en    out  1         read enable, RAM16x16
//  busy       out  1         high in every state except IDLE
//  done       out  1         one-cycle pulse at the end of a job
// BEHAVIOUR
//  RAM contract:
//  - Read data appears 1 cycle after op_en and is held until the next op_en.
//  - A write completes at the edge on which w_en is high.
//  - The product A*B (16 bit, unsigned, no truncation) is combinational from the RAM16x8 outputs.
//  Reset values: all outputs 0; state=IDLE; idx=0; cnt=0.
//  IDLE
//  - start=1, count!=0: latch cnt=count, idx=0, go to LOAD.
//  - start=1, count==0: go to DONE.
//  LOAD
//  - in_ready=1. ab_w_en = in_valid (combinational). ab_addr = idx.
//  - On each handshake idx++. On the handshake with idx==cnt-1: idx=0, go to CALC.
//  CALC (pipelined, cnt+1 cycles)
//  - Cycle k<cnt: ab_op_en=1, ab_addr=k.
//  - Cycle k>=1: c_w_en=1, c_addr=k-1.
//  - After the write with c_addr=cnt-1: idx=0, go to RD.
//  RD (1 cycle)
//  - c_op_en=1, c_addr=idx. Go to OUT.
//  OUT
//  - out_valid=1 until out_ready. On the handshake: idx++.
//  - If idx==cnt-1 go to DONE, else go to RD. Throughput is 1 word per 2 cycles.
//  DONE
//  - done=1 for one cycle; busy=0. Then IDLE.
//  Rules:
//  - idx and cnt are ADDR_W+1 bits wide. count=DEPTH uses addresses 0..DEPTH-1.
//  - Addresses never wrap past DEPTH-1.
//  - count>DEPTH is clamped to DEPTH.
//  - start outside IDLE is ignored, including the DONE cycle.
//  - in_valid outside LOAD is ignored; in_ready=0.
//  - out_valid must not drop without out_ready. c_addr is stable while out_valid=1.
//  - reset at any time: return to IDLE immediately and drop all enables.
//    RAM contents are not defined after reset mid-job.
//  - start and reset high together: reset wins.
//  - Enables are mutually exclusive per RAM; no cycle drives w_en and op_en together.
// TESTING
//  1 count=3; A={2,3,255}, B={5,7,255}; out_ready=1
//    -> outputs 10,21,65025 in order; done pulses once; busy low afterwards.
//  2 Same job with out_ready toggling 1-of-3 cycles
//    -> same values, no drop or duplicate; out_valid/c_addr stable while stalled.
//  3 count=16, A[i]=i, B[i]=i+1; in_valid gapped randomly
//    -> 16 products i*(i+1); ab_addr/c_addr reach 15, never 0 mid-run.
//  4 count=0 start -> done on the 2nd cycle, no enable ever asserted.
//    count=20 -> behaves as 16.
//  5 reset asserted in CALC at k=2 -> next cycle all enables 0, state IDLE;
//    a new count=1 job (A=9,B=9) then outputs 81.
//  6 start pulsed during LOAD and during DONE
//    -> ignored; in_valid pulsed during OUT -> in_ready=0, no ab_w_en.

Source files
------------

// File: rtl/mul_ram_sequencer_if.sv
// Handshake and RAM-control bundle of mul_ram_sequencer.
// slave = sequencer side, master = job source and product consumer.
interface mul_ram_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              start;
   logic [ADDR_W:0]   count;
   logic              in_valid;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] ab_addr;
   logic              ab_w_en;
   logic              ab_op_en;
   logic [ADDR_W-1:0] c_addr;
   logic              c_w_en;
   logic              c_op_en;
   logic              busy;
   logic              done;

   modport slave (
      input  start, count, in_valid, out_ready,
      output in_ready, out_valid,
      output ab_addr, ab_w_en, ab_op_en,
      output c_addr, c_w_en, c_op_en,
      output busy, done
   );

   modport master (
      output start, count, in_valid, out_ready,
      input  in_ready, out_valid,
      input  ab_addr, ab_w_en, ab_op_en,
      input  c_addr, c_w_en, c_op_en,
      input  busy, done
   );
endinterface

// File: rtl/mul_ram_sequencer.sv
// Sequencer for the dual RAM16x8 -> multiplier -> RAM16x16 datapath:
// load operands, pipelined multiply pass, stream products out, pulse done.
module mul_ram_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   mul_ram_sequencer_if.slave bus
);
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] MAXC = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CALC, S_RD, S_OUT, S_DONE
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic in_ready_q, in_ready_d;
   logic out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] ab_addr_q, ab_addr_d;
   logic ab_op_en_q, ab_op_en_d;
   logic [ADDR_W-1:0] c_addr_q, c_addr_d;
   logic c_w_en_q, c_w_en_d;
   logic c_op_en_q, c_op_en_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic in_hs;
   logic out_hs;
   logic last;

   assign in_hs  = in_ready_q & bus.in_valid;
   assign out_hs = out_valid_q & bus.out_ready;
   assign last   = (idx_q == cnt_q - ONE);

   // Next state, index and latched count.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
                  idx_d   = '0;
                  cnt_d   = (bus.count > MAXC) ? MAXC : bus.count;
               end
            end
         end
         S_LOAD: begin
            if (in_hs) begin
               if (last) begin
                  idx_d   = '0;
                  state_d = S_CALC;
               end else begin
                  idx_d = idx_q + ONE;
               end
            end
         end
         S_CALC: begin
            // idx walks 0..cnt; the final step only drains the write.
            if (idx_q == cnt_q) begin
               idx_d   = '0;
               state_d = S_RD;
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         S_RD: begin
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_hs) begin
               if (last) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + ONE;
                  state_d = S_RD;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the next state so they leave straight from flops.
   always_comb begin
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      ab_addr_d   = '0;
      ab_op_en_d  = 1'b0;
      c_addr_d    = '0;
      c_w_en_d    = 1'b0;
      c_op_en_d   = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      unique case (state_d)
         S_LOAD: begin
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            ab_addr_d  = ADDR_W'(idx_d);
         end
         S_CALC: begin
            busy_d = 1'b1;
            if (idx_d < cnt_d) begin
               ab_op_en_d = 1'b1;
               ab_addr_d  = ADDR_W'(idx_d);
            end else begin
               ab_addr_d = ADDR_W'(cnt_d - ONE);
            end
            if (idx_d != '0) begin
               c_w_en_d = 1'b1;
               c_addr_d = ADDR_W'(idx_d - ONE);
            end
         end
         S_RD: begin
            busy_d    = 1'b1;
            c_op_en_d = 1'b1;
            c_addr_d  = ADDR_W'(idx_d);
         end
         S_OUT: begin
            busy_d      = 1'b1;
            out_valid_d = 1'b1;
            c_addr_d    = ADDR_W'(idx_d);
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops every enable at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         ab_addr_q   <= '0;
         ab_op_en_q  <= 1'b0;
         c_addr_q    <= '0;
         c_w_en_q    <= 1'b0;
         c_op_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         ab_addr_q   <= ab_addr_d;
         ab_op_en_q  <= ab_op_en_d;
         c_addr_q    <= c_addr_d;
         c_w_en_q    <= c_w_en_d;
         c_op_en_q   <= c_op_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ab_addr   = ab_addr_q;
   assign bus.ab_w_en   = in_hs;
   assign bus.ab_op_en  = ab_op_en_q;
   assign bus.c_addr    = c_addr_q;
   assign bus.c_w_en    = c_w_en_q;
   assign bus.c_op_en   = c_op_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule
